ysyx_23060208_axil_rd_master: RTL and testbench

//  AXI-Lite read initiator: accepts one word-read request from a core-side unit (LSU/IFU)
//  and drives the AR/R channels toward a responder (CLINT, SRAM, UART).

---
 rtl/ysyx_23060208_axil_pkg.sv | 38 +++
 rtl/ysyx_23060208_rd_timer.sv | 45 ++++
 rtl/ysyx_23060208_axil_rd_master.sv | 173 +++++++++++++++++
 tb/tb_ysyx_23060208_axil_rd_master.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060208_axil_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060208_axil_pkg
// Shared definitions for the AXI-Lite read initiator:
//   - AXI response encodings (RESP_OKAY/EXOKAY/SLVERR/DECERR)
//   - read-FSM state enum (ST_DRAIN exists only when AXIL_RD_TIMEOUT_EN is defined)
//   - resp_is_error(): classifies an R-channel response code
// Optional feature macro: AXIL_RD_TIMEOUT_EN
// ----------------------------------------------------------------------------
package ysyx_23060208_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef AXIL_RD_TIMEOUT_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AR    = 3'd1,
        ST_R     = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } rd_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AR    = 3'd1,
        ST_R     = 3'd2,
        ST_RESP  = 3'd3
    } rd_state_e;
`endif

    // Anything other than OKAY is reported to the core as an error.
    function automatic logic resp_is_error(input logic [1:0] rresp);
        return (rresp != RESP_OKAY);
    endfunction

endpackage

// File: rtl/ysyx_23060208_rd_timer.sv
// ----------------------------------------------------------------------------
// ysyx_23060208_rd_timer
// Loadable up-counter with an expiry flag, used to bound the R-channel wait.
// Ports:
//   clk      in  clock (rising edge)
//   rst      in  asynchronous active-low reset
//   load     in  load count with load_val (has priority over en)
//   load_val in  value loaded on load
//   en       in  count one per cycle; saturates at LIMIT-1
//   expired  out en && count == LIMIT-1
// Only instantiated when AXIL_RD_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module ysyx_23060208_rd_timer #(
    parameter int unsigned LIMIT = 256
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        load,
    input  logic [((LIMIT > 1) ? $clog2(LIMIT) : 1)-1:0] load_val,
    input  logic                                        en,
    output logic                                        expired
);

    localparam int unsigned   CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1'b1);

    logic [CW-1:0] count_r;

    // Count register: load wins, otherwise count up while enabled until LAST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != LAST)) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = en && (count_r == LAST);

endmodule

// File: rtl/ysyx_23060208_axil_rd_master.sv
// ----------------------------------------------------------------------------
// ysyx_23060208_axil_rd_master
// AXI-Lite read initiator: takes one word read from the core, runs AR then R,
// and holds the response until the core takes it. One transaction in flight.
// Ports:
//   clk, rst (async active-low)
//   core side : req_valid/req_ready/req_addr, resp_valid/resp_ready/resp_rdata/resp_err
//   AXI side  : m_araddr/m_arvalid/m_arready, m_rdata/m_rresp/m_rvalid/m_rready
// Optional feature macro: AXIL_RD_TIMEOUT_EN -- bounds the R wait to
// TIMEOUT_CYCLES, reports a timeout as an error and drains the late R beat.
// ----------------------------------------------------------------------------
module ysyx_23060208_axil_rd_master
    import ysyx_23060208_axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    rd_state_e             state_r;
    rd_state_e             state_s;
    logic                  aligned_s;
    logic                  m_arvalid_r;
    logic                  m_rready_r;
    logic                  resp_valid_r;
    logic [DATA_WIDTH-1:0] resp_rdata_r;
    logic                  resp_err_r;
    logic [ADDR_WIDTH-1:0] m_araddr_r;

    assign aligned_s  = (req_addr[1:0] == 2'b00);
    assign req_ready  = (state_r == ST_IDLE);
    assign m_arvalid  = m_arvalid_r;
    assign m_rready   = m_rready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign m_araddr   = m_araddr_r;

`ifdef AXIL_RD_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic timeout_s;
    logic timed_out_r;

    // Timer is held at zero outside R, so every R entry starts from 0.
    ysyx_23060208_rd_timer #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_rd_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state_r != ST_R),
        .load_val ({TW{1'b0}}),
        .en       (state_r == ST_R),
        .expired  (timeout_s)
    );

    // Remembers that the pending response came from a timeout so RESP exits to DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timed_out_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            timed_out_r <= 1'b0;
        end else if (state_r == ST_R) begin
            timed_out_r <= timeout_s && !m_rvalid;
        end else begin
            timed_out_r <= timed_out_r;
        end
    end
`endif

    // Next-state logic. In IDLE req_ready is 1, so req_valid alone is the handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) state_s = aligned_s ? ST_AR : ST_RESP;
                else           state_s = ST_IDLE;
            end
            ST_AR: begin
                if (m_arready) state_s = ST_R;
                else           state_s = ST_AR;
            end
            ST_R: begin
                // A beat arriving on the expiry cycle wins over the timeout.
                if (m_rvalid)       state_s = ST_RESP;
`ifdef AXIL_RD_TIMEOUT_EN
                else if (timeout_s) state_s = ST_RESP;
`endif
                else                state_s = ST_R;
            end
            ST_RESP: begin
`ifdef AXIL_RD_TIMEOUT_EN
                if (resp_ready) state_s = timed_out_r ? ST_DRAIN : ST_IDLE;
`else
                if (resp_ready) state_s = ST_IDLE;
`endif
                else            state_s = ST_RESP;
            end
`ifdef AXIL_RD_TIMEOUT_EN
            ST_DRAIN: begin
                if (m_rvalid) state_s = ST_IDLE;
                else          state_s = ST_DRAIN;
            end
`endif
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and handshake outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            m_arvalid_r  <= 1'b0;
            m_rready_r   <= 1'b0;
            resp_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            m_arvalid_r  <= (state_s == ST_AR);
`ifdef AXIL_RD_TIMEOUT_EN
            m_rready_r   <= (state_s == ST_R) || (state_s == ST_DRAIN);
`else
            m_rready_r   <= (state_s == ST_R);
`endif
            resp_valid_r <= (state_s == ST_RESP);
        end
    end

    // Address latch and response capture; values hold while waiting on the core.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_araddr_r   <= {ADDR_WIDTH{1'b0}};
            resp_rdata_r <= {DATA_WIDTH{1'b0}};
            resp_err_r   <= 1'b0;
        end else if ((state_r == ST_IDLE) && req_valid) begin
            if (aligned_s) begin
                m_araddr_r <= req_addr;
            end else begin
                resp_rdata_r <= {DATA_WIDTH{1'b0}};
                resp_err_r   <= 1'b1;
            end
        end else if ((state_r == ST_R) && m_rvalid) begin
            resp_rdata_r <= m_rdata;
            resp_err_r   <= resp_is_error(m_rresp);
`ifdef AXIL_RD_TIMEOUT_EN
        end else if ((state_r == ST_R) && timeout_s) begin
            resp_rdata_r <= {DATA_WIDTH{1'b0}};
            resp_err_r   <= 1'b1;
`endif
        end else begin
            m_araddr_r   <= m_araddr_r;
            resp_rdata_r <= resp_rdata_r;
            resp_err_r   <= resp_err_r;
        end
    end

endmodule

// File: tb/tb_ysyx_23060208_axil_rd_master.sv
// ----------------------------------------------------------------------------
// Self-checking bench for ysyx_23060208_axil_rd_master. A cycle-level slave
// model answers AR/R with chosen delays; expected latency, data, error and
// handshake counts come from the transaction-level rules (misaligned -> error
// one cycle later, otherwise 3 + AR stall + R delay cycles).
// ----------------------------------------------------------------------------
module tb_ysyx_23060208_axil_rd_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic [1:0]  m_rresp = 2'b00;
    logic        m_rvalid = 1'b0;
    logic        m_rready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_23060208_axil_rd_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .m_araddr   (m_araddr),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .m_rdata    (m_rdata),
        .m_rresp    (m_rresp),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full read: request, slave model, response check, back-pressure, release.
    task automatic run_read(input logic [31:0] addr, input int ar_delay, input int r_delay,
                            input logic [31:0] rdata, input logic [1:0] rresp,
                            input int hold, input bit junk, input string name);
        logic        misal;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_cyc;
        int          exp_ar;
        int          cyc;
        int          ar_hs;
        int          ar_extra;
        int          r_hs;
        int          aw;
        int          rw;
        bit          ar_done;
        bit          pend;
        bit          addr_ok;
        misal    = (addr[1:0] != 2'b00);
        exp_err  = misal || (rresp != 2'b00);
        exp_data = misal ? 32'h0 : rdata;
        exp_cyc  = misal ? 1 : 3 + ar_delay + r_delay;
        exp_ar   = misal ? 0 : 1;

        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL %s/idle_ready: got %b expected 1", name, req_ready);
        end
        req_valid = 1'b1; req_addr = addr;
        step();
        req_valid = 1'b0; req_addr = $urandom;

        cyc = 1; ar_hs = 0; ar_extra = 0; r_hs = 0; aw = ar_delay; rw = r_delay;
        ar_done = 1'b0; pend = 1'b0; addr_ok = 1'b1;
        while (resp_valid !== 1'b1 && cyc < 200) begin
            if (pend) ar_done = 1'b1;
            pend = 1'b0;
            if (m_arvalid === 1'b1 && (misal || m_araddr !== addr)) addr_ok = 1'b0;
            if (ar_done && m_arvalid === 1'b1) ar_extra++;
            if (!ar_done && m_arvalid === 1'b1) begin
                if (aw == 0) begin m_arready = 1'b1; ar_hs++; pend = 1'b1; end
                else begin m_arready = 1'b0; aw--; end
            end else begin
                m_arready = 1'b0;
            end
            if (ar_done && r_hs == 0) begin
                if (rw == 0) begin
                    m_rvalid = 1'b1; m_rdata = rdata; m_rresp = rresp;
                    if (m_rready === 1'b1) r_hs++;
                end else begin
                    m_rvalid = 1'b0; rw--;
                end
            end else if (junk && !ar_done) begin
                m_rvalid = 1'($urandom_range(0, 1)); m_rdata = $urandom; m_rresp = 2'b10;
            end else begin
                m_rvalid = 1'b0;
            end
            step();
            cyc++;
        end
        m_arready = 1'b0; m_rvalid = 1'b0;

        checks++;
        if (cyc != exp_cyc) begin
            errors++; $display("FAIL %s/latency: got %0d expected %0d", name, cyc, exp_cyc);
        end
        checks++;
        if (resp_rdata !== exp_data) begin
            errors++; $display("FAIL %s/rdata: got %h expected %h", name, resp_rdata, exp_data);
        end
        checks++;
        if (resp_err !== exp_err) begin
            errors++; $display("FAIL %s/err: got %b expected %b", name, resp_err, exp_err);
        end
        checks++;
        if (ar_hs != exp_ar || ar_extra != 0 || !addr_ok) begin
            errors++; $display("FAIL %s/ar: got hs=%0d extra=%0d addr_ok=%0d expected hs=%0d extra=0 addr_ok=1",
                               name, ar_hs, ar_extra, addr_ok, exp_ar);
        end

        for (int i = 0; i < hold; i++) begin
            checks++;
            if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== exp_data ||
                resp_err !== exp_err || m_arvalid !== 1'b0 || m_rready !== 1'b0) begin
                errors++;
                $display("FAIL %s/hold%0d: got ready=%b valid=%b data=%h err=%b arv=%b rr=%b expected 0 1 %h %b 0 0",
                         name, i, req_ready, resp_valid, resp_rdata, resp_err, m_arvalid, m_rready,
                         exp_data, exp_err);
            end
            req_valid = 1'b1; req_addr = {$urandom_range(0, 32'hffff), 2'b00};
            m_rvalid = 1'($urandom_range(0, 1)); m_rdata = $urandom;
            step();
        end
        req_valid = 1'b0; m_rvalid = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL %s/release: got valid=%b ready=%b expected 0 1", name, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        checks++;
        if (m_arvalid !== 1'b0 || m_rready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 ||
            resp_err !== 1'b0 || m_araddr !== 32'h0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: got arv=%b rr=%b rv=%b data=%h err=%b addr=%h rdy=%b expected 0 0 0 0 0 0 1",
                     m_arvalid, m_rready, resp_valid, resp_rdata, resp_err, m_araddr, req_ready);
        end
        step(); step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        run_read(32'ha0000048, 0, 0, 32'h1, 2'b00, 0, 1'b0, "basic");
    endtask

    task automatic test_ar_stall();
        run_read(32'ha0000100, 5, 0, 32'h12345678, 2'b00, 1, 1'b1, "ar_stall");
    endtask

    task automatic test_slverr();
        run_read(32'h80000010, 0, 2, 32'hdead, 2'b10, 0, 1'b0, "slverr");
    endtask

    task automatic test_misaligned();
        run_read(32'h80000002, 0, 0, 32'hffffffff, 2'b00, 2, 1'b1, "misaligned");
    endtask

    task automatic test_backpressure();
        run_read(32'h80000020, 1, 1, 32'hcafef00d, 2'b00, 4, 1'b0, "backpressure");
    endtask

    task automatic test_late_beat_edge();
        run_read(32'h80000040, 0, TO - 1, 32'h5a5a5a5a, 2'b00, 0, 1'b0, "r_at_limit");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_read({$urandom_range(0, 32'h3fffffff), 2'b00}, 0, 0, $urandom, 2'b00, 0, 1'b0, "b2b");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            run_read(a, $urandom_range(0, 4), $urandom_range(0, 4), $urandom,
                     2'($urandom_range(0, 3)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_reset_in_ar();
        req_valid = 1'b1; req_addr = 32'h80000080;
        step();
        req_valid = 1'b0; m_arready = 1'b0;
        step(); step();
        checks++;
        if (m_arvalid !== 1'b1 || m_araddr !== 32'h80000080) begin
            errors++; $display("FAIL rst_ar/pre: got arv=%b addr=%h expected 1 80000080", m_arvalid, m_araddr);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (m_arvalid !== 1'b0 || req_ready !== 1'b1 || m_araddr !== 32'h0) begin
            errors++; $display("FAIL rst_ar/async: got arv=%b rdy=%b addr=%h expected 0 1 0", m_arvalid, req_ready, m_araddr);
        end
        step();
        rst = 1'b1;
        step();
        checks++;
        if (m_arvalid !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_ar/after: got arv=%b rv=%b expected 0 0", m_arvalid, resp_valid);
        end
        run_read(32'h800000c0, 0, 1, 32'h0badf00d, 2'b00, 0, 1'b0, "after_rst");
    endtask

`ifdef AXIL_RD_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        req_valid = 1'b1; req_addr = 32'h80000200;
        step();
        req_valid = 1'b0;
        cyc = 1;
        while (resp_valid !== 1'b1 && cyc < 200) begin
            m_arready = (m_arvalid === 1'b1);
            m_rvalid  = 1'b0;
            step();
            cyc++;
        end
        m_arready = 1'b0;
        checks++;
        if (cyc != 2 + TO || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
            errors++; $display("FAIL timeout/resp: got cyc=%0d err=%b data=%h expected %0d 1 0",
                               cyc, resp_err, resp_rdata, 2 + TO);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_addr = 32'h80000300;
            checks++;
            if (req_ready !== 1'b0 || m_rready !== 1'b1 || m_arvalid !== 1'b0) begin
                errors++; $display("FAIL timeout/drain%0d: got rdy=%b rr=%b arv=%b expected 0 1 0",
                                   i, req_ready, m_rready, m_arvalid);
            end
            step();
        end
        req_valid = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hbeef;
        step();
        m_rvalid = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || m_rready !== 1'b0) begin
            errors++; $display("FAIL timeout/exit: got rdy=%b rv=%b rr=%b expected 1 0 0", req_ready, resp_valid, m_rready);
        end
        run_read(32'h80000400, 0, 0, 32'h77, 2'b00, 0, 1'b0, "post_timeout");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_ar_stall();
        test_slverr();
        test_misaligned();
        test_backpressure();
        test_late_beat_edge();
        test_back_to_back();
        test_random();
`ifdef AXIL_RD_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_in_ar();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
